// File: rtl/key_cond_pkg.sv
// Shared types, timing defaults and width helpers for the KEY[0] step conditioner.
// The DBG_* values shrink every interval so a simulation covers whole press cycles in a few dozen clocks.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        REPEAT     = 2'd2
    } key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;

    localparam int DBG_DEBOUNCE_CYCLES = 4;
    localparam int DBG_REPEAT_DELAY    = 10;
    localparam int DBG_REPEAT_PERIOD   = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold every value from 0 up to and including max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus stable-run counter that turns the raw active-low key
// into a clean active-high level in the CLOCK_50 domain.
module debounce_filter
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLOCK_50,
    input  logic KEY3_n,
    input  logic raw_n,
    output logic level
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_n;
    logic          sync2_n;
    logic          sync;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two synchroniser stages into one.
    always_ff @(posedge CLOCK_50 or negedge KEY3_n) begin
        if (!KEY3_n) begin
            sync1_n <= 1'b1;
            sync2_n <= 1'b1;
        end else begin
            sync1_n <= raw_n;
            sync2_n <= sync1_n;
        end
    end

    assign sync = ~sync2_n;

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge CLOCK_50 or negedge KEY3_n) begin
        if (!KEY3_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync != level) begin
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/key_step_conditioner.sv
// Converts the bouncy KEY[0] into a one-cycle LFSR step enable with optional auto-repeat,
// and exports the debounced level and repeat status for the LEDs.
module key_step_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic CLOCK_50,
    input  logic KEY3_n,
    input  logic key_n,
    output logic step,
    output logic held,
    output logic repeat_active
);

    localparam int            TW          = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TW-1:0] LOAD_DELAY  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] LOAD_PERIOD = TW'(REPEAT_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(1);

    key_state_t    state;
    key_state_t    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          expire;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLOCK_50(CLOCK_50),
        .KEY3_n  (KEY3_n),
        .raw_n   (key_n),
        .level   (held)
    );

    // NOTE: every register here, timers included, sits on the asynchronous reset so
    // the outputs go quiet the instant KEY3_n drops, without waiting for a clock.
    always_ff @(posedge CLOCK_50 or negedge KEY3_n) begin
        if (!KEY3_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // The timer reads 1 in the cycle a delay or period runs out; it then rests at 0.
    assign expire = (timer == TIMER_LAST);

    // NOTE: all outputs of this block get a default before the case so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        timer_next = (timer != '0) ? timer - 1'b1 : '0;
        step       = 1'b0;

        unique case (state)
            IDLE: begin
                timer_next = '0;
                if (held) begin
                    step       = 1'b1;
                    timer_next = LOAD_DELAY;
                    state_next = WAIT_DELAY;
                end
            end
            WAIT_DELAY: begin
                if (!held) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else if (expire && REPEAT_EN) begin
                    step       = 1'b1;
                    timer_next = LOAD_PERIOD;
                    state_next = REPEAT;
                end
            end
            REPEAT: begin
                if (!held) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else if (expire) begin
                    step       = 1'b1;
                    timer_next = LOAD_PERIOD;
                end
            end
            default: begin
                timer_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // High from the cycle of the first auto-repeat step through the last cycle the key is held.
    assign repeat_active = (state_next == REPEAT);

endmodule

// File: tb/tb_key_step_conditioner.sv
// Bench for key_step_conditioner: directed press scenarios plus random bouncy presses,
// with both REPEAT_EN settings driven from the same key and checked against a timing model.
module tb_key_step_conditioner;
    import key_cond_pkg::*;

    localparam int D  = DBG_DEBOUNCE_CYCLES;
    localparam int RD = DBG_REPEAT_DELAY;
    localparam int RP = DBG_REPEAT_PERIOD;

    logic CLOCK_50 = 1'b0;
    logic KEY3_n;
    logic key_n;
    logic step1, held1, rep1;
    logic step0, held0, rep0;

    always #5 CLOCK_50 = ~CLOCK_50;

    key_step_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)
    ) dut (
        .CLOCK_50(CLOCK_50), .KEY3_n(KEY3_n), .key_n(key_n),
        .step(step1), .held(held1), .repeat_active(rep1)
    );

    key_step_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)
    ) dut_norep (
        .CLOCK_50(CLOCK_50), .KEY3_n(KEY3_n), .key_n(key_n),
        .step(step0), .held(held0), .repeat_active(rep0)
    );

    int checks   = 0;
    int failures = 0;

    // Model: pressed samples taken at each edge, the current run of disagreement,
    // the debounced level and the cycle on which the current press was accepted.
    bit samples[$];
    int run     = 0;
    bit held_m  = 1'b0;
    int cyc     = 0;
    int press_t = 0;

    // Per-scenario log, cycle numbers relative to the scenario start.
    int rel = 0;
    int st1_q[$];
    int st0_q[$];
    int rep_first = -1;
    int rep_last  = -1;
    int rep0_seen = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at rel cycle %0d: observed=%b expected=%b", tag, rel, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit exp_step(input bit en);
        int k = cyc - press_t;
        return held_m && (k == 0 || (en && k >= RD && ((k - RD) % RP) == 0));
    endfunction

    function automatic bit exp_rep(input bit en);
        return en && held_m && ((cyc - press_t) >= RD);
    endfunction

    task automatic model_edge();
        bit s;
        bit prev;
        s    = (samples.size() >= 2) ? samples[samples.size() - 2] : 1'b0;
        prev = held_m;
        run  = (s != held_m) ? run + 1 : 0;
        if (run == D) begin
            held_m = ~held_m;
            run    = 0;
        end
        samples.push_back(~key_n);
        if (samples.size() > 2) void'(samples.pop_front());
        cyc++;
        if (held_m && !prev) press_t = cyc;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_edge();
        rel++;
        #1;
        check("step_rep", step1, exp_step(1'b1));
        check("held_rep", held1, held_m);
        check("repact_rep", rep1, exp_rep(1'b1));
        check("step_norep", step0, exp_step(1'b0));
        check("held_norep", held0, held_m);
        check("repact_norep", rep0, exp_rep(1'b0));
        if (step1) st1_q.push_back(rel);
        if (step0) st0_q.push_back(rel);
        if (rep1) begin
            if (rep_first < 0) rep_first = rel;
            rep_last = rel;
        end
        if (rep0) rep0_seen++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        rel = 0;
        st1_q.delete();
        st0_q.delete();
        rep_first = -1;
        rep_last  = -1;
        rep0_seen = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_step"}, step1, 1'b0);
        check({tag, "_held"}, held1, 1'b0);
        check({tag, "_repact"}, rep1, 1'b0);
        check({tag, "_step0"}, step0, 1'b0);
        check({tag, "_held0"}, held0, 1'b0);
        check({tag, "_repact0"}, rep0, 1'b0);
    endtask

    // Drops KEY3_n between clock edges and checks the outputs clear without an edge.
    task automatic async_reset(input string tag);
        #2;
        KEY3_n = 1'b0;
        #1;
        check_zero_outputs(tag);
        samples.delete();
        run    = 0;
        held_m = 1'b0;
    endtask

    // Releases reset inside a cycle, which becomes cycle 0 of the next scenario.
    task automatic release_reset();
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #2;
        KEY3_n = 1'b1;
        clear_log();
    endtask

    initial begin
        int exp_clean[8];
        exp_clean = '{6, 16, 19, 22, 25, 28, 31, 34};

        // Reset with the key already pressed.
        KEY3_n = 1'b1;
        key_n  = 1'b1;
        #1;
        KEY3_n = 1'b0;
        key_n  = 1'b0;
        #1;
        check_zero_outputs("reset_pressed");
        release_reset();
        ticks(8);
        check_int("reset_first_step_cycle", (st1_q.size() > 0) ? st1_q[0] : -1, 6);
        check_int("reset_step_count", st1_q.size(), 1);
        key_n = 1'b1;
        ticks(12);

        // Clean hold from cycle 0, released at cycle 30.
        clear_log();
        key_n = 1'b0;
        ticks(30);
        key_n = 1'b1;
        ticks(15);
        check_int("clean_step_count", st1_q.size(), 8);
        for (int i = 0; i < 8 && i < st1_q.size(); i++)
            check_int($sformatf("clean_step%0d_cycle", i), st1_q[i], exp_clean[i]);
        check_int("clean_repact_first", rep_first, 16);
        check_int("clean_repact_last", rep_last, 35);
        check_int("clean_norep_step_count", st0_q.size(), 1);

        // Bounce every 2 cycles for 20 cycles, then a steady press from cycle 20.
        clear_log();
        for (int i = 0; i < 20; i++) begin
            key_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        key_n = 1'b0;
        ticks(8);
        check_int("bounce_step_count", st1_q.size(), 1);
        check_int("bounce_step_cycle", (st1_q.size() > 0) ? st1_q[0] : -1, 26);
        key_n = 1'b1;
        ticks(12);

        // Three-cycle glitch must be rejected outright.
        clear_log();
        key_n = 1'b0;
        ticks(3);
        key_n = 1'b1;
        ticks(12);
        check_int("glitch_step_count", st1_q.size() + st0_q.size(), 0);

        // Long hold: the non-repeating instance steps once and never reports repeat.
        clear_log();
        key_n = 1'b0;
        ticks(50);
        key_n = 1'b1;
        ticks(12);
        check_int("norep_step_count", st0_q.size(), 1);
        check_int("norep_step_cycle", (st0_q.size() > 0) ? st0_q[0] : -1, 6);
        check_int("norep_repact_cycles", rep0_seen, 0);

        // Reset while repeating, key still down; the press sequence restarts from scratch.
        clear_log();
        key_n = 1'b0;
        ticks(20);
        check("pre_reset_in_repeat", rep1, 1'b1);
        async_reset("reset_in_repeat");
        release_reset();
        ticks(20);
        check_int("restart_first_step_cycle", (st1_q.size() > 0) ? st1_q[0] : -1, 6);
        check_int("restart_repact_first", rep_first, 16);
        key_n = 1'b1;
        ticks(12);

        // Random presses with bounces of up to D cycles per segment.
        for (int n = 0; n < 30; n++) begin
            int nb;
            nb = $urandom_range(0, 6);
            for (int b = 0; b < nb; b++) begin
                key_n = ~key_n;
                ticks($urandom_range(1, D));
            end
            key_n = 1'($urandom_range(0, 1));
            ticks($urandom_range(1, 40));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
